// File: rtl/hamming74_encoder_if.sv
// Valid/ready streams of the Hamming(7,4) encoder: nibble input and codeword output.
// The master drives the input stream and accepts codewords; the encoder is the slave.
interface hamming74_encoder_if;
  logic [0:3] data_in;
  logic [2:0] err_pos;
  logic       in_valid;
  logic       in_ready;
  logic [0:6] code_out;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output data_in, err_pos, in_valid, out_ready,
    input  in_ready, code_out, out_valid
  );

  modport slave (
    input  data_in, err_pos, in_valid, out_ready,
    output in_ready, code_out, out_valid
  );
endinterface

// File: rtl/hamming74_encoder.sv
// Streaming Hamming(7,4) encoder: FIFO-buffered nibbles become registered 7-bit codewords,
// with optional per-word single-bit error injection for decoder test traffic.
module hamming74_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     active,
  hamming74_encoder_if.slave       bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         words_sent
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [6:0]       mem_q [DEPTH];
  logic [0:6]       code_q, code_d;
  logic             out_valid_q;
  logic [CNT_W-1:0] words_sent_q;

  logic       full, empty, push, load, xfer;
  logic [6:0] head;
  logic [0:3] head_d;
  logic [2:0] head_err;
  logic [0:6] flip_mask;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push = bus.in_valid && !full;
  assign load = active && !empty && (!out_valid_q || bus.out_ready);
  assign xfer = out_valid_q && bus.out_ready;

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_d   = head[6:3];
  assign head_err = head[2:0];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    flip_mask = '0;
    if (head_err != 3'd7) flip_mask = 7'b1000000 >> head_err;
    code_d = {head_d,
              head_d[0] ^ head_d[1] ^ head_d[3],
              head_d[0] ^ head_d[2] ^ head_d[3],
              head_d[1] ^ head_d[2] ^ head_d[3]} ^ flip_mask;
  end

  // NOTE: the FIFO storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.data_in, bus.err_pos};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      code_q       <= '0;
      out_valid_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (xfer) words_sent_q <= words_sent_q + 1'b1;
      if (load) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        code_q      <= code_d;
        out_valid_q <= 1'b1;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.code_out  = code_q;
  assign bus.out_valid = out_valid_q;
  assign fifo_level    = wr_ptr_q - rd_ptr_q;
  assign words_sent    = words_sent_q;

endmodule

// File: tb/tb_hamming74_encoder.sv
// Self-checking bench for hamming74_encoder: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the stream behaviour.
module tb_hamming74_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          active;
  logic [LW-1:0] fifo_level;
  logic [CNT_W-1:0] words_sent;

  hamming74_encoder_if bus ();

  hamming74_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .bus        (bus),
    .fifo_level (fifo_level),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [0:3] d;
    logic [2:0] e;
  } entry_t;

  // Reference model state.
  entry_t     m_fifo[$];
  logic [0:6] m_sent_q[$];
  logic [0:6] d_sent_q[$];
  bit         m_ov;
  logic [0:6] m_code;
  int         m_cnt;
  bit         m_push, m_load;
  entry_t     m_head;

  function automatic logic [0:6] ref_encode(logic [0:3] d, logic [2:0] e);
    int         b[7];
    logic [0:6] c;
    for (int i = 0; i < 4; i++) b[i] = d[i] ? 1 : 0;
    b[4] = (b[0] + b[1] + b[3]) % 2;
    b[5] = (b[0] + b[2] + b[3]) % 2;
    b[6] = (b[1] + b[2] + b[3]) % 2;
    if (e < 7) b[e] = 1 - b[e];
    for (int i = 0; i < 7; i++) c[i] = (b[i] == 1);
    return c;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      m_sent_q.delete();
      m_ov   = 1'b0;
      m_code = '0;
      m_cnt  = 0;
    end else begin
      m_push = bus.in_valid && (m_fifo.size() < DEPTH);
      m_load = active && (m_fifo.size() > 0) && (!m_ov || bus.out_ready);
      if (m_ov && bus.out_ready) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_sent_q.push_back(m_code);
        if (!m_load) m_ov = 1'b0;
      end
      if (m_load) begin
        m_head = m_fifo.pop_front();
        m_code = ref_encode(m_head.d, m_head.e);
        m_ov   = 1'b1;
      end
      if (m_push) m_fifo.push_back('{d: bus.data_in, e: bus.err_pos});
    end
  end

  // Records every codeword the DUT actually hands over.
  always @(posedge clk or negedge reset) begin
    if (!reset) d_sent_q.delete();
    else if (bus.out_valid && bus.out_ready) d_sent_q.push_back(bus.code_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [0:3] d, logic [2:0] e);
    bus.in_valid = v;
    bus.data_in  = d;
    bus.err_pos  = e;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    active = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'b0000, 3'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    active = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'b0000, 3'd7);
    #2;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    n_checks++; if (bus.code_out !== 7'b0000000) begin n_fail++; $display("FAIL reset_code_out: got %b, expected 0000000", bus.code_out); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_fifo_level: got %0d, expected 0", fifo_level); end
    n_checks++; if (words_sent !== '0) begin n_fail++; $display("FAIL reset_words_sent: got %0d, expected 0", words_sent); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [0:3] din [5];
    logic [0:6] exp [5];
    din[0] = 4'b1011; din[1] = 4'b0000; din[2] = 4'b1111; din[3] = 4'b0001; din[4] = 4'b1000;
    exp[0] = 7'b1011010; exp[1] = 7'b0000000; exp[2] = 7'b1111111; exp[3] = 7'b0001111; exp[4] = 7'b1000110;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 5) drive(1'b1, din[c], 3'd7);
      else drive(1'b0, 4'b0000, 3'd7);
      @(negedge clk);
      if (c >= 2 && c <= 6) begin
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b, expected 1", c - 2, bus.out_valid); end
        n_checks++; if (bus.code_out !== exp[c-2]) begin n_fail++; $display("FAIL basic_code[%0d]: got %b, expected %b", c - 2, bus.code_out, exp[c-2]); end
      end else begin
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid[c=%0d]: got %b, expected 0", c, bus.out_valid); end
      end
      tick();
    end
    n_checks++; if (words_sent !== 4'd5) begin n_fail++; $display("FAIL basic_words_sent: got %0d, expected 5", words_sent); end
  endtask

  task automatic test_err_inject();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1'b1, 4'b1011, 3'd2);
      else if (c == 1) drive(1'b1, 4'b1011, 3'd6);
      else drive(1'b0, 4'b0000, 3'd7);
      @(negedge clk);
      if (c == 2) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.code_out !== 7'b1001010) begin n_fail++; $display("FAIL err_pos2: got v=%b %b, expected v=1 1001010", bus.out_valid, bus.code_out); end
      end
      if (c == 3) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.code_out !== 7'b1011011) begin n_fail++; $display("FAIL err_pos6: got v=%b %b, expected v=1 1011011", bus.out_valid, bus.code_out); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [0:3] w [6];
    int  idx = 0;
    bit  acc;
    for (int i = 0; i < 6; i++) w[i] = 4'($urandom);
    apply_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, w[idx], 3'd7);
      @(negedge clk);
      acc = (m_fifo.size() < DEPTH);
      if (c >= 2) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.code_out !== ref_encode(w[0], 3'd7)) begin n_fail++; $display("FAIL bp_hold[c=%0d]: got v=%b %b, expected v=1 %b", c, bus.out_valid, bus.code_out, ref_encode(w[0], 3'd7)); end
      end
      tick();
      if (acc) idx++;
    end
    @(negedge clk);
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d, expected 4", fifo_level); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, expected 0", bus.in_ready); end
    n_checks++; if (idx != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d, expected 5", idx); end
    tick();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) drive(1'b1, w[idx], 3'd7);
      else drive(1'b0, 4'b0000, 3'd7);
      acc = (idx < 6) && (m_fifo.size() < DEPTH);
      tick();
      if (acc) idx++;
      if (c == 4) begin
        n_checks++; if (d_sent_q.size() != 5) begin n_fail++; $display("FAIL bp_rate: got %0d words, expected 5", d_sent_q.size()); end
      end
    end
    n_checks++; if (d_sent_q.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d, expected 6", d_sent_q.size()); end
    for (int i = 0; i < 6 && i < d_sent_q.size(); i++) begin
      n_checks++; if (d_sent_q[i] !== ref_encode(w[i], 3'd7)) begin n_fail++; $display("FAIL bp_order[%0d]: got %b, expected %b", i, d_sent_q[i], ref_encode(w[i], 3'd7)); end
    end
  endtask

  task automatic test_inactive();
    logic [0:3] w [3];
    for (int i = 0; i < 3; i++) w[i] = 4'($urandom);
    apply_reset();
    active = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1'b1, w[c], 3'd7);
      else drive(1'b0, 4'b0000, 3'd7);
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL inactive_valid[c=%0d]: got %b, expected 0", c, bus.out_valid); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL inactive_level: got %0d, expected 3", fifo_level); end
    tick();
    active = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.code_out !== ref_encode(w[0], 3'd7)) begin n_fail++; $display("FAIL inactive_first: got v=%b %b, expected v=1 %b", bus.out_valid, bus.code_out, ref_encode(w[0], 3'd7)); end
    repeat (5) tick();
    n_checks++; if (d_sent_q.size() != 3) begin n_fail++; $display("FAIL inactive_count: got %0d, expected 3", d_sent_q.size()); end
    for (int i = 0; i < 3 && i < d_sent_q.size(); i++) begin
      n_checks++; if (d_sent_q[i] !== ref_encode(w[i], 3'd7)) begin n_fail++; $display("FAIL inactive_order[%0d]: got %b, expected %b", i, d_sent_q[i], ref_encode(w[i], 3'd7)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [0:3] w [2];
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c < 2, 4'($urandom), 3'd7);
      tick();
    end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(c < 3, 4'($urandom), 3'd7);
      tick();
    end
    @(negedge clk);
    n_checks++; if (fifo_level !== 3'd2 || bus.out_valid !== 1'b1 || words_sent !== 4'd2) begin n_fail++; $display("FAIL midrst_pre: got lvl=%0d v=%b ws=%0d, expected lvl=2 v=1 ws=2", fifo_level, bus.out_valid, words_sent); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", bus.out_valid); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL midrst_level: got %0d, expected 0", fifo_level); end
    n_checks++; if (words_sent !== '0) begin n_fail++; $display("FAIL midrst_words: got %0d, expected 0", words_sent); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b, expected 1", bus.in_ready); end
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    w[0] = 4'($urandom);
    w[1] = 4'($urandom);
    for (int c = 0; c < 6; c++) begin
      if (c < 2) drive(1'b1, w[c], 3'd7);
      else drive(1'b0, 4'b0000, 3'd7);
      tick();
    end
    n_checks++; if (d_sent_q.size() != 2) begin n_fail++; $display("FAIL midrst_count: got %0d, expected 2", d_sent_q.size()); end
    for (int i = 0; i < 2 && i < d_sent_q.size(); i++) begin
      n_checks++; if (d_sent_q[i] !== ref_encode(w[i], 3'd7)) begin n_fail++; $display("FAIL midrst_order[%0d]: got %b, expected %b", i, d_sent_q[i], ref_encode(w[i], 3'd7)); end
    end
  endtask

  task automatic test_counter_wrap();
    logic [0:6] exp[$];
    logic [0:3] d;
    logic [2:0] e;
    apply_reset();
    for (int c = 0; c < 21; c++) begin
      if (c < 17) begin
        d = 4'($urandom);
        e = 3'($urandom);
        exp.push_back(ref_encode(d, e));
        drive(1'b1, d, e);
      end else begin
        drive(1'b0, 4'b0000, 3'd7);
      end
      tick();
    end
    n_checks++; if (words_sent !== 4'd1) begin n_fail++; $display("FAIL wrap_words_sent: got %0d, expected 1", words_sent); end
    n_checks++; if (d_sent_q.size() != 17) begin n_fail++; $display("FAIL wrap_count: got %0d, expected 17", d_sent_q.size()); end
    for (int i = 0; i < 17 && i < d_sent_q.size(); i++) begin
      n_checks++; if (d_sent_q[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %b, expected %b", i, d_sent_q[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(99) < 70, 4'($urandom), 3'($urandom));
      bus.out_ready = $urandom_range(99) < 60;
      active = $urandom_range(99) < 85;
      @(negedge clk);
      n_checks++; if (bus.in_ready !== (m_fifo.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b, expected %b", c, bus.in_ready, m_fifo.size() < DEPTH); end
      n_checks++; if (bus.out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b, expected %b", c, bus.out_valid, m_ov); end
      if (m_ov) begin
        n_checks++; if (bus.code_out !== m_code) begin n_fail++; $display("FAIL rnd_code[%0d]: got %b, expected %b", c, bus.code_out, m_code); end
      end
      n_checks++; if (fifo_level !== LW'(m_fifo.size())) begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d, expected %0d", c, fifo_level, m_fifo.size()); end
      n_checks++; if (words_sent !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_words[%0d]: got %0d, expected %0d", c, words_sent, m_cnt); end
      tick();
    end
    drive(1'b0, 4'b0000, 3'd7);
    bus.out_ready = 1'b1;
    active = 1'b1;
    repeat (8) tick();
    n_checks++; if (d_sent_q.size() != m_sent_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d, expected %0d", d_sent_q.size(), m_sent_q.size()); end
    for (int i = 0; i < m_sent_q.size() && i < d_sent_q.size(); i++) begin
      n_checks++; if (d_sent_q[i] !== m_sent_q[i]) begin n_fail++; $display("FAIL rnd_order[%0d]: got %b, expected %b", i, d_sent_q[i], m_sent_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err_inject();
    test_backpressure();
    test_inactive();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
